dispensador_billetes: RTL and testbench
=======================================

DISPENSADOR_BILLETES -- requirements
Module: dispensador_billetes

Interface
REQ-001 SHALL use one clock and an asynchronous active-high reset, named as the codebase does:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-002 SHALL have the control and data ports:
- entregar_dinero  in  1  one-cycle request from cajero_atm to dispense.
- monto  in  32  amount in colones; valid in the entregar_dinero cycle.
- carga_stb  in  1  inventory load strobe.
- carga_denom  in  3  denomination code to load.
- carga_cant  in  16  bill count written to that denomination.
- dispensa_ack  in  1  mechanism acknowledge, one bill delivered.
- billete_stb  out  1  request for one bill.
- billete_denom  out  3  denomination code of the requested bill.
- ocupado  out  1  high whenever not in IDLE.
- dispensado_ok  out  1  one-cycle pulse when all bills are delivered.
- monto_invalido  out  1  one-cycle error pulse.
- sin_billetes  out  1  one-cycle error pulse.
- falla_mecanica  out  1  one-cycle error pulse.
- estado_disp  out  3  current state encoding, for debug.

Function
REQ-003 SHALL map denomination codes 0..4 to 20000, 10000, 5000, 2000 and 1000 colones; codes 5..7 SHALL be ignored on load.
REQ-004 SHALL implement the states IDLE, VALIDAR, PLANEAR, DISPENSAR, ESPERA_ACK, PAUSA and FIN.
REQ-005 In IDLE, entregar_dinero=1 SHALL capture monto into resto and go to VALIDAR; carga_stb in the same cycle SHALL be ignored.
REQ-006 In IDLE with carga_stb=1 and entregar_dinero=0, the inventory entry for carga_denom SHALL be overwritten with carga_cant.
REQ-007 entregar_dinero and carga_stb SHALL be ignored outside IDLE.
REQ-008 VALIDAR SHALL pulse monto_invalido and return to IDLE if any of these hold; otherwise it SHALL go to PLANEAR:
- resto==0
- resto is not a multiple of 1000
- resto > MAX_RETIRO (400000)
REQ-009 PLANEAR SHALL perform one greedy step per cycle, largest denomination first:
- if resto >= denom and plan[d] < inventory[d]: increment plan[d] and subtract denom from resto;
- otherwise advance to the next denomination.
REQ-010 When PLANEAR finishes the last denomination with resto != 0, it SHALL pulse sin_billetes, return to IDLE, and leave the inventory unchanged.
REQ-011 When PLANEAR finishes with resto == 0, it SHALL go to DISPENSAR.
REQ-012 DISPENSAR SHALL select the largest denomination with plan[d] > 0, assert billete_stb with billete_denom=d, and go to ESPERA_ACK.
REQ-013 In ESPERA_ACK, billete_stb and billete_denom SHALL be held stable until dispensa_ack=1 is sampled.
REQ-014 On that ack edge the block SHALL:
- decrement plan[d] and inventory[d];
- drop billete_stb;
- enter PAUSA for exactly one cycle.
REQ-015 From PAUSA the block SHALL go to DISPENSAR if any plan[d] > 0, otherwise to FIN.
REQ-016 FIN SHALL pulse dispensado_ok for one cycle and then return to IDLE.
REQ-017 dispensa_ack while billete_stb=0 SHALL be ignored.
REQ-018 If ESPERA_ACK lasts TIMEOUT_ACK (1024) cycles without an ack, the block SHALL:
- pulse falla_mecanica;
- drop billete_stb;
- clear the plan;
- return to IDLE with the inventory reflecting only bills already acknowledged.
REQ-019 The first billete_stb SHALL rise exactly 3 + P cycles after the entregar_dinero edge, where P is the number of PLANEAR cycles.
REQ-020 Inventory counters SHALL NOT wrap, because a decrement happens only when the counter is greater than 0.
REQ-021 At most one of dispensado_ok, monto_invalido, sin_billetes and falla_mecanica SHALL be high in any cycle.

Reset
REQ-022 Reset SHALL force state IDLE and clear resto, plan, and all inventory counters.
REQ-023 Reset SHALL force every output to 0.
REQ-024 Reset asserted mid-dispense SHALL abort with no completion or error pulse.

Structure
REQ-025 The denomination values, the codes 0..4, MAX_RETIRO, TIMEOUT_ACK and the state encodings SHALL live in the shared cajero package/include.
REQ-026 The five inventory counters, with their load and decrement ports, SHALL form one sub-module, inventario_billetes.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Load all denominations with 10; request 38000 -> bills 20000, 10000, 5000, 2000, 1000 in that order; dispensado_ok; inventory 9,9,9,9,9.
- Request 1500 -> monto_invalido; request 0 -> monto_invalido; request 401000 -> monto_invalido; no billete_stb in any case.
- Inventory 20000:0, 10000:1, others 0; request 20000 -> sin_billetes; inventory unchanged.
- After the second ack of a request for 3×1000, hold ack low for 1024 cycles -> falla_mecanica; 1000 inventory decremented by 2.
- Assert reset during ESPERA_ACK -> all outputs 0 immediately; inventory 0; a subsequent request returns sin_billetes.
- Pulse entregar_dinero and carga_stb while ocupado=1 -> both ignored; the current transaction completes unchanged.

Source files
------------

// File: rtl/dispensador_billetes_pkg.sv
// Shared cajero definitions: denomination codes and values, withdrawal limit,
// mechanism acknowledge timeout and the dispenser state encoding.
package dispensador_billetes_pkg;

    localparam int NUM_DENOM   = 5;
    localparam int CANT_W      = 16;
    localparam int TIMEOUT_ACK = 1024;

    localparam logic [31:0] MAX_RETIRO = 32'd400000;

    localparam logic [2:0] COD_20000 = 3'd0;
    localparam logic [2:0] COD_10000 = 3'd1;
    localparam logic [2:0] COD_5000  = 3'd2;
    localparam logic [2:0] COD_2000  = 3'd3;
    localparam logic [2:0] COD_1000  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_VALIDAR    = 3'd1,
        ST_PLANEAR    = 3'd2,
        ST_DISPENSAR  = 3'd3,
        ST_ESPERA_ACK = 3'd4,
        ST_PAUSA      = 3'd5,
        ST_FIN        = 3'd6
    } estado_t;

    typedef logic [NUM_DENOM-1:0][CANT_W-1:0] cant_vec_t;

    function automatic logic [31:0] valor_denom(input logic [2:0] cod);
        case (cod)
            COD_20000: return 32'd20000;
            COD_10000: return 32'd10000;
            COD_5000:  return 32'd5000;
            COD_2000:  return 32'd2000;
            COD_1000:  return 32'd1000;
            default:   return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dispensador_billetes_inventario.sv
// Five bill counters: overwritten by a load, decremented by one per delivered bill.
// A counter at zero never decrements, so it cannot wrap.
module inventario_billetes
    import dispensador_billetes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              carga_en,
    input  logic [2:0]        carga_denom,
    input  logic [CANT_W-1:0] carga_cant,
    input  logic              dec_en,
    input  logic [2:0]        dec_denom,
    output cant_vec_t         cant
);

    cant_vec_t cant_q, cant_d;

    // Codes 5..7 match no counter and are dropped here.
    always_comb begin
        cant_d = cant_q;
        for (int d = 0; d < NUM_DENOM; d++) begin
            if (carga_en && carga_denom == 3'(d)) begin
                cant_d[d] = carga_cant;
            end else if (dec_en && dec_denom == 3'(d) && cant_q[d] != '0) begin
                cant_d[d] = cant_q[d] - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cant_q <= '0;
        end else begin
            cant_q <= cant_d;
        end
    end

    assign cant = cant_q;

endmodule

// File: rtl/dispensador_billetes.sv
// Bill dispenser: validates a requested amount, plans a greedy bill mix against
// the inventory, then hands bills to the mechanism one at a time with an ack timeout.
module dispensador_billetes
    import dispensador_billetes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              entregar_dinero,
    input  logic [31:0]       monto,
    input  logic              carga_stb,
    input  logic [2:0]        carga_denom,
    input  logic [CANT_W-1:0] carga_cant,
    input  logic              dispensa_ack,
    output logic              billete_stb,
    output logic [2:0]        billete_denom,
    output logic              ocupado,
    output logic              dispensado_ok,
    output logic              monto_invalido,
    output logic              sin_billetes,
    output logic              falla_mecanica,
    output logic [2:0]        estado_disp
);

    localparam logic [9:0] TIMER_CARGA = 10'(TIMEOUT_ACK - 1);
    localparam logic [2:0] ULTIMA      = 3'(NUM_DENOM - 1);

    estado_t     estado_q, estado_d;
    logic [31:0] resto_q, resto_d;
    cant_vec_t   plan_q, plan_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  denom_q, denom_d;
    logic [9:0]  timer_q, timer_d;
    logic        stb_q, stb_d;

    cant_vec_t   inv_cant;
    logic        monto_malo, puede_tomar, plan_fin, plan_pendiente;
    logic        ack_ok, timer_tc, carga_en, dec_en;
    logic [2:0]  sel_denom;

    inventario_billetes u_inv (
        .clk         (clk),
        .reset       (reset),
        .carga_en    (carga_en),
        .carga_denom (carga_denom),
        .carga_cant  (carga_cant),
        .dec_en      (dec_en),
        .dec_denom   (denom_q),
        .cant        (inv_cant)
    );

    assign monto_malo     = (resto_q == '0) || ((resto_q % 32'd1000) != '0) || (resto_q > MAX_RETIRO);
    assign puede_tomar    = (resto_q >= valor_denom(idx_q)) && (plan_q[idx_q] < inv_cant[idx_q]);
    assign plan_fin       = !puede_tomar && (idx_q == ULTIMA);
    assign plan_pendiente = |plan_q;
    assign ack_ok         = dispensa_ack && stb_q;
    assign timer_tc       = (timer_q == '0);
    assign carga_en       = (estado_q == ST_IDLE) && carga_stb && !entregar_dinero;
    assign dec_en         = (estado_q == ST_ESPERA_ACK) && ack_ok;

    always_comb begin
        sel_denom = '0;
        for (int d = NUM_DENOM - 1; d >= 0; d--) begin
            if (plan_q[d] != '0) sel_denom = 3'(d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= ST_IDLE;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ST_IDLE:       if (entregar_dinero) estado_d = ST_VALIDAR;
            ST_VALIDAR:    estado_d = monto_malo ? ST_IDLE : ST_PLANEAR;
            ST_PLANEAR:    if (plan_fin) estado_d = (resto_q == '0) ? ST_DISPENSAR : ST_IDLE;
            ST_DISPENSAR:  estado_d = ST_ESPERA_ACK;
            ST_ESPERA_ACK: begin
                if (ack_ok)        estado_d = ST_PAUSA;
                else if (timer_tc) estado_d = ST_IDLE;
            end
            ST_PAUSA:      estado_d = plan_pendiente ? ST_DISPENSAR : ST_FIN;
            ST_FIN:        estado_d = ST_IDLE;
            default:       estado_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ocupado        = (estado_q != ST_IDLE);
        monto_invalido = (estado_q == ST_VALIDAR) && monto_malo;
        sin_billetes   = (estado_q == ST_PLANEAR) && plan_fin && (resto_q != '0);
        falla_mecanica = (estado_q == ST_ESPERA_ACK) && !ack_ok && timer_tc;
        dispensado_ok  = (estado_q == ST_FIN);
        estado_disp    = estado_q;
        billete_stb    = stb_q;
        billete_denom  = denom_q;
    end

    always_comb begin
        resto_d = resto_q;
        plan_d  = plan_q;
        idx_d   = idx_q;
        denom_d = denom_q;
        timer_d = timer_q;
        case (estado_q)
            ST_IDLE: if (entregar_dinero) resto_d = monto;
            ST_VALIDAR: idx_d = '0;
            ST_PLANEAR: begin
                if (puede_tomar) begin
                    plan_d[idx_q] = plan_q[idx_q] + 16'd1;
                    resto_d       = resto_q - valor_denom(idx_q);
                end else if (idx_q != ULTIMA) begin
                    idx_d = idx_q + 3'd1;
                end else if (resto_q != '0) begin
                    plan_d = '0;
                end
            end
            ST_DISPENSAR: begin
                denom_d = sel_denom;
                timer_d = TIMER_CARGA;
            end
            ST_ESPERA_ACK: begin
                if (ack_ok) begin
                    plan_d[denom_q] = plan_q[denom_q] - 16'd1;
                end else if (timer_tc) begin
                    plan_d = '0;
                end else begin
                    timer_d = timer_q - 10'd1;
                end
            end
            default: ;
        endcase
    end

    // The strobe rises one cycle into ESPERA_ACK and falls on the accepted ack or timeout.
    assign stb_d = (estado_q == ST_ESPERA_ACK) && (estado_d == ST_ESPERA_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resto_q <= '0;
            plan_q  <= '0;
            idx_q   <= '0;
            denom_q <= '0;
            timer_q <= '0;
            stb_q   <= 1'b0;
        end else begin
            resto_q <= resto_d;
            plan_q  <= plan_d;
            idx_q   <= idx_d;
            denom_q <= denom_d;
            timer_q <= timer_d;
            stb_q   <= stb_d;
        end
    end

endmodule

// File: tb/tb_dispensador_billetes.sv
// Self-checking bench: greedy-plan reference model over an inventory array,
// randomized ack delays and requests, directed boundary scenarios.
module tb_dispensador_billetes;
    import dispensador_billetes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        entregar_dinero;
    logic [31:0] monto;
    logic        carga_stb;
    logic [2:0]  carga_denom;
    logic [15:0] carga_cant;
    logic        dispensa_ack;
    logic        billete_stb;
    logic [2:0]  billete_denom;
    logic        ocupado, dispensado_ok, monto_invalido, sin_billetes, falla_mecanica;
    logic [2:0]  estado_disp;

    int n_cmp = 0;
    int n_err = 0;
    int inv_m [NUM_DENOM];
    int valores [NUM_DENOM] = '{20000, 10000, 5000, 2000, 1000};

    always #5 clk = ~clk;

    dispensador_billetes dut (
        .clk             (clk),
        .reset           (reset),
        .entregar_dinero (entregar_dinero),
        .monto           (monto),
        .carga_stb       (carga_stb),
        .carga_denom     (carga_denom),
        .carga_cant      (carga_cant),
        .dispensa_ack    (dispensa_ack),
        .billete_stb     (billete_stb),
        .billete_denom   (billete_denom),
        .ocupado         (ocupado),
        .dispensado_ok   (dispensado_ok),
        .monto_invalido  (monto_invalido),
        .sin_billetes    (sin_billetes),
        .falla_mecanica  (falla_mecanica),
        .estado_disp     (estado_disp)
    );

    task automatic cargar(input int d, input int cant);
        @(negedge clk);
        carga_stb   = 1'b1;
        carga_denom = 3'(d);
        carga_cant  = 16'(cant);
        @(negedge clk);
        carga_stb   = 1'b0;
        if (d < NUM_DENOM) inv_m[d] = cant;
    endtask

    // kind: 0 ok, 1 monto_invalido, 2 sin_billetes, 3 falla_mecanica
    task automatic run_request(input logic [31:0] m, input int stall_after, input bit perturbar,
                               input string nombre);
        int kind, got, rest, n, p_cycles, idx, acks, bi, esp_run, ack_wait, exp_bi;
        int bills[$];
        bit fin, prev_stb;
        rest = 0; p_cycles = 0; got = -1;
        if (m == 0 || (m % 1000) != 0 || m > 400000) begin
            kind = 1;
        end else begin
            rest = int'(m);
            for (int d = 0; d < NUM_DENOM; d++) begin
                n = rest / valores[d];
                if (n > inv_m[d]) n = inv_m[d];
                repeat (n) bills.push_back(d);
                rest -= n * valores[d];
            end
            p_cycles = bills.size() + NUM_DENOM;
            if (rest != 0) kind = 2;
            else if (stall_after >= 0 && stall_after < bills.size()) kind = 3;
            else kind = 0;
        end

        @(negedge clk);
        entregar_dinero = 1'b1;
        monto = m;
        if (perturbar) begin
            carga_stb = 1'b1; carga_denom = COD_1000; carga_cant = 16'd777;
        end
        @(negedge clk);
        entregar_dinero = 1'b0;
        carga_stb = 1'b0;
        monto = $urandom;

        idx = 0; acks = 0; bi = 0; esp_run = 0; ack_wait = 0; fin = 0; prev_stb = 0;
        while (!fin && idx < 5000) begin
            if (dispensado_ok || monto_invalido || sin_billetes || falla_mecanica) begin
                n_cmp++;
                if (int'(dispensado_ok) + int'(monto_invalido) + int'(sin_billetes) + int'(falla_mecanica) != 1) begin
                    n_err++;
                    $display("FAIL %s pulsos_exclusivos: got %b%b%b%b need one-hot", nombre,
                             dispensado_ok, monto_invalido, sin_billetes, falla_mecanica);
                end
            end
            if (estado_disp == ST_ESPERA_ACK) esp_run++; else esp_run = 0;
            if (billete_stb && !prev_stb) begin
                if (bi == 0) begin
                    n_cmp++;
                    if (idx != 3 + p_cycles) begin
                        n_err++;
                        $display("FAIL %s latencia_stb: got %0d need %0d", nombre, idx, 3 + p_cycles);
                    end
                end
                n_cmp++;
                if (bi >= bills.size() || int'(billete_denom) != bills[bi]) begin
                    n_err++;
                    $display("FAIL %s denom_billete[%0d]: got %0d need %0d", nombre, bi, billete_denom,
                             (bi < bills.size()) ? bills[bi] : -1);
                end
                bi++;
                ack_wait = $urandom_range(0, 3);
            end
            if (dispensado_ok)  begin got = 0; fin = 1; end
            if (monto_invalido) begin got = 1; fin = 1; end
            if (sin_billetes)   begin got = 2; fin = 1; end
            if (falla_mecanica) begin
                got = 3; fin = 1;
                n_cmp++;
                if (esp_run != TIMEOUT_ACK) begin
                    n_err++;
                    $display("FAIL %s ciclos_timeout: got %0d need %0d", nombre, esp_run, TIMEOUT_ACK);
                end
            end
            prev_stb = billete_stb;

            dispensa_ack = 1'b0;
            if (billete_stb) begin
                if (stall_after < 0 || acks < stall_after) begin
                    if (ack_wait == 0) begin
                        n_cmp++;
                        if (bi < 1 || int'(billete_denom) != bills[bi-1]) begin
                            n_err++;
                            $display("FAIL %s denom_estable: got %0d", nombre, billete_denom);
                        end
                        dispensa_ack = 1'b1;
                        acks++;
                    end else begin
                        ack_wait--;
                    end
                end
            end else if (ocupado && $urandom_range(0, 3) == 0) begin
                dispensa_ack = 1'b1;
            end
            if (perturbar && ocupado && !fin && $urandom_range(0, 2) == 0) begin
                entregar_dinero = 1'b1;
                monto       = 32'($urandom_range(1, 40) * 1000);
                carga_stb   = 1'b1;
                carga_denom = 3'($urandom_range(0, 4));
                carga_cant  = 16'($urandom_range(0, 60000));
            end else begin
                entregar_dinero = 1'b0;
                carga_stb = 1'b0;
            end
            if (!fin) begin
                @(negedge clk);
                idx++;
            end
        end
        dispensa_ack = 1'b0; entregar_dinero = 1'b0; carga_stb = 1'b0;

        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL %s sin_fin: no completion within 5000 cycles", nombre);
        end
        n_cmp++;
        if (got != kind) begin
            n_err++;
            $display("FAIL %s resultado: got %0d need %0d", nombre, got, kind);
        end
        exp_bi = (kind == 0) ? bills.size() : (kind == 3) ? stall_after + 1 : 0;
        n_cmp++;
        if (bi != exp_bi) begin
            n_err++;
            $display("FAIL %s num_strobes: got %0d need %0d", nombre, bi, exp_bi);
        end
        if (kind == 0) foreach (bills[i]) inv_m[bills[i]]--;
        if (kind == 3) for (int i = 0; i < stall_after; i++) inv_m[bills[i]]--;

        @(negedge clk);
        n_cmp++;
        if (ocupado !== 1'b0 || billete_stb !== 1'b0) begin
            n_err++;
            $display("FAIL %s vuelta_idle: got ocupado=%b stb=%b need 0 0", nombre, ocupado, billete_stb);
        end
        for (int d = 0; d < NUM_DENOM; d++) begin
            n_cmp++;
            if (int'(dut.inv_cant[d]) != inv_m[d]) begin
                n_err++;
                $display("FAIL %s inventario[%0d]: got %0d need %0d", nombre, d, dut.inv_cant[d], inv_m[d]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        entregar_dinero = 0; monto = 0; carga_stb = 0; carga_denom = 0; carga_cant = 0; dispensa_ack = 0;
        foreach (inv_m[d]) inv_m[d] = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({billete_stb, billete_denom, ocupado, dispensado_ok, monto_invalido, sin_billetes,
             falla_mecanica, estado_disp} !== '0) begin
            n_err++;
            $display("FAIL reset_salidas: got %b need 0", {billete_stb, billete_denom, ocupado,
                     dispensado_ok, monto_invalido, sin_billetes, falla_mecanica, estado_disp});
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut.inv_cant !== '0 || estado_disp !== 3'd0) begin
            n_err++;
            $display("FAIL reset_estado: got inv=%h estado=%0d need 0", dut.inv_cant, estado_disp);
        end
    endtask

    task automatic test_dispensa_basico;
        for (int d = 0; d < NUM_DENOM; d++) cargar(d, 10);
        cargar(5, 3);
        run_request(32'd38000, -1, 0, "mezcla_38000");
        run_request(32'd7000, -1, 0, "mezcla_7000");
    endtask

    task automatic test_montos_invalidos;
        run_request(32'd1500, -1, 0, "invalido_1500");
        run_request(32'd0, -1, 0, "invalido_0");
        run_request(32'd401000, -1, 0, "invalido_401000");
        cargar(COD_20000, 20);
        run_request(32'd400000, -1, 0, "limite_400000");
    endtask

    task automatic test_sin_billetes;
        for (int d = 0; d < NUM_DENOM; d++) cargar(d, (d == 1) ? 1 : 0);
        run_request(32'd20000, -1, 0, "sin_billetes_20000");
    endtask

    task automatic test_timeout;
        for (int d = 0; d < NUM_DENOM; d++) cargar(d, (d == 4) ? 5 : 0);
        run_request(32'd3000, 2, 0, "timeout_3x1000");
    endtask

    task automatic test_reset_en_espera;
        int espera;
        cargar(COD_1000, 2);
        @(negedge clk);
        entregar_dinero = 1'b1; monto = 32'd1000;
        @(negedge clk);
        entregar_dinero = 1'b0;
        espera = 0;
        while (!billete_stb && espera < 50) begin
            @(negedge clk);
            espera++;
        end
        n_cmp++;
        if (!billete_stb) begin
            n_err++;
            $display("FAIL reset_espera_stb: got no strobe within 50 cycles");
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({billete_stb, billete_denom, ocupado, dispensado_ok, monto_invalido, sin_billetes,
             falla_mecanica, estado_disp} !== '0 || dut.inv_cant !== '0) begin
            n_err++;
            $display("FAIL reset_espera_salidas: got %b inv=%h need 0", {billete_stb, billete_denom,
                     ocupado, dispensado_ok, monto_invalido, sin_billetes, falla_mecanica, estado_disp},
                     dut.inv_cant);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        foreach (inv_m[d]) inv_m[d] = 0;
        run_request(32'd1000, -1, 0, "post_reset_1000");
    endtask

    task automatic test_ignorar_ocupado;
        for (int d = 0; d < NUM_DENOM; d++) cargar(d, 10);
        run_request(32'd38000, -1, 1, "ocupado_38000");
        run_request(32'd24000, -1, 1, "ocupado_24000");
    endtask

    task automatic test_aleatorio;
        logic [31:0] m;
        int r;
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) cargar($urandom_range(0, 7), $urandom_range(0, 6));
            end
            r = $urandom_range(0, 9);
            if (r < 7)       m = 32'($urandom_range(1, 60) * 1000);
            else if (r == 7) m = 32'($urandom_range(0, 50) * 1000 + 500);
            else if (r == 8) m = 32'($urandom_range(401, 450) * 1000);
            else             m = 32'd0;
            run_request(m, -1, 1'($urandom_range(0, 1)), "aleatorio");
        end
    endtask

    initial begin
        test_reset();
        test_dispensa_basico();
        test_montos_invalidos();
        test_sin_billetes();
        test_timeout();
        test_reset_en_espera();
        test_ignorar_ocupado();
        test_aleatorio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
